id_regfile_bypass: RTL and testbench

- Decode-stage operand source for the 5-stage MIPS pipeline.
- Holds a 32x32 general-purpose register file with one write port and two combinational read ports.
- Each read port feeds a 4:1 bypass multiplexer that picks one of four values: register file, EX ALU result, MEM ALU result, or MEM load data.
- Drives the ALU A/B operands (a_id, b_id) toward the ID/EX latch.

---
 rtl/id_regfile_bypass_pkg.sv | 16 +
 rtl/id_regfile_bypass_mux4.sv | 27 ++
 rtl/id_regfile_bypass.sv | 63 ++++++
 tb/tb_id_regfile_bypass.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_regfile_bypass_pkg.sv
// Shared decode-stage definitions: datapath widths and the operand bypass-select
// encodings, common to the register file and the hazard/decode logic.
package id_regfile_bypass_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        SEL_RF     = 2'b00,
        SEL_EX_ALU = 2'b01,
        SEL_ME_ALU = 2'b10,
        SEL_ME_MEM = 2'b11
    } bypass_sel_e;

endpackage

// File: rtl/id_regfile_bypass_mux4.sv
// 4:1 operand bypass multiplexer choosing between the register file and the
// three forwarding sources from later pipeline stages.
module bypass_mux4
    import id_regfile_bypass_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_rf,
    input  logic [WIDTH-1:0] in_ex_alu,
    input  logic [WIDTH-1:0] in_me_alu,
    input  logic [WIDTH-1:0] in_me_mem,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = in_rf;
        case (bypass_sel_e'(sel))
            SEL_RF:     y = in_rf;
            SEL_EX_ALU: y = in_ex_alu;
            SEL_ME_ALU: y = in_me_alu;
            SEL_ME_MEM: y = in_me_mem;
            default:    y = in_rf;
        endcase
    end

endmodule

// File: rtl/id_regfile_bypass.sv
// Decode-stage operand source: 32x32 register file (falling-edge write, two
// combinational reads) with a 4:1 bypass mux on each read port.
module id_regfile_bypass
    import id_regfile_bypass_pkg::*;
#(
    parameter int DATA_W = id_regfile_bypass_pkg::DATA_W,
    parameter int ADDR_W = id_regfile_bypass_pkg::ADDR_W,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              we,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] data_w,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] ans_me,
    input  logic [DATA_W-1:0] mo_me,
    input  logic [1:0]        a_select,
    input  logic [1:0]        b_select,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    output logic [DATA_W-1:0] a_id,
    output logic [DATA_W-1:0] b_id
);

    logic [DATA_W-1:0] regs [NREGS];

    // Writing on the falling edge lets an ID-stage read of the WB destination
    // see the new value within the same cycle, so WB->ID needs no bypass.
    always_ff @(negedge clock or posedge reset_0) begin
        if (reset_0) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rw != '0)) begin
            regs[rw] <= data_w;
        end
    end

    assign data_a = (rs == '0) ? '0 : regs[rs];
    assign data_b = (rt == '0) ? '0 : regs[rt];

    bypass_mux4 #(.WIDTH(DATA_W)) u_mux_a (
        .sel       (a_select),
        .in_rf     (data_a),
        .in_ex_alu (ans_ex),
        .in_me_alu (ans_me),
        .in_me_mem (mo_me),
        .y         (a_id)
    );

    bypass_mux4 #(.WIDTH(DATA_W)) u_mux_b (
        .sel       (b_select),
        .in_rf     (data_b),
        .in_ex_alu (ans_ex),
        .in_me_alu (ans_me),
        .in_me_mem (mo_me),
        .y         (b_id)
    );

endmodule

// File: tb/tb_id_regfile_bypass.sv
// Scoreboard bench for id_regfile_bypass: directed stimulus pushes hand-computed
// expectations, a monitor process samples the outputs and compares.
module tb_id_regfile_bypass;

    logic        clock;
    logic        reset_0;
    logic        we;
    logic [4:0]  rs, rt, rw;
    logic [31:0] data_w, ans_ex, ans_me, mo_me;
    logic [1:0]  a_select, b_select;
    logic [31:0] data_a, data_b, a_id, b_id;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] aid;
        logic [31:0] bid;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   tests_run;
    int   tests_failed;

    id_regfile_bypass dut (
        .clock    (clock),
        .reset_0  (reset_0),
        .we       (we),
        .rs       (rs),
        .rt       (rt),
        .rw       (rw),
        .data_w   (data_w),
        .ans_ex   (ans_ex),
        .ans_me   (ans_me),
        .mo_me    (mo_me),
        .a_select (a_select),
        .b_select (b_select),
        .data_a   (data_a),
        .data_b   (data_b),
        .a_id     (a_id),
        .b_id     (b_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp_field(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, exp);
        end
    endtask

    // Monitor: one sample per pushed expectation, taken 1 time unit after the push.
    initial begin
        exp_t e;
        forever begin
            @(push_ev);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cmp_field(e.name, "data_a", data_a, e.a);
                cmp_field(e.name, "data_b", data_b, e.b);
                cmp_field(e.name, "a_id",   a_id,   e.aid);
                cmp_field(e.name, "b_id",   b_id,   e.bid);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] ea,
                                input logic [31:0] eb, input logic [31:0] eaid,
                                input logic [31:0] ebid);
        exp_t e;
        int   waited;
        e.name = name;
        e.a    = ea;
        e.b    = eb;
        e.aid  = eaid;
        e.bid  = ebid;
        exp_q.push_back(e);
        -> push_ev;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3) begin
            #1;
            waited++;
        end
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s.timeout: got queue depth %0d, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input logic [4:0] addr, input logic [31:0] value);
        @(posedge clock);
        #2;
        we     = 1'b1;
        rw     = addr;
        data_w = value;
        @(negedge clock);
        #2;
        we = 1'b0;
    endtask

    initial begin
        logic [31:0] sweep_exp [4];
        tests_run    = 0;
        tests_failed = 0;
        reset_0  = 1'b1;
        we       = 1'b0;
        rs       = 5'd5;
        rt       = 5'd31;
        rw       = 5'd0;
        data_w   = 32'h0;
        ans_ex   = 32'h0;
        ans_me   = 32'h0;
        mo_me    = 32'h0;
        a_select = 2'b00;
        b_select = 2'b00;

        #12;
        check_output("reset_held", 32'h0, 32'h0, 32'h0, 32'h0);
        @(posedge clock);
        #2;
        reset_0 = 1'b0;
        check_output("reset_released", 32'h0, 32'h0, 32'h0, 32'h0);

        apply_stimulus(5'd0, 32'hDEADBEEF);
        rs = 5'd0;
        rt = 5'd0;
        check_output("r0_write_dropped", 32'h0, 32'h0, 32'h0, 32'h0);

        // Falling-edge write visible within the same cycle
        @(posedge clock);
        #2;
        we     = 1'b1;
        rw     = 5'd3;
        data_w = 32'h12345678;
        rs     = 5'd3;
        check_output("wr_before_fall", 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clock);
        #1;
        check_output("wr_after_fall", 32'h12345678, 32'h0, 32'h12345678, 32'h0);
        we = 1'b0;

        @(posedge clock);
        #2;
        we     = 1'b0;
        rw     = 5'd3;
        data_w = 32'hCAFEF00D;
        @(negedge clock);
        #2;
        check_output("we0_keeps", 32'h12345678, 32'h0, 32'h12345678, 32'h0);

        apply_stimulus(5'd7, 32'hA5A5A5A5);
        apply_stimulus(5'd9, 32'h0000FFFF);
        rs = 5'd7;
        rt = 5'd9;
        check_output("dual_read", 32'hA5A5A5A5, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF);
        rt = 5'd7;
        check_output("same_reg_read", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

        apply_stimulus(5'd4, 32'd4);
        ans_ex = 32'd1;
        ans_me = 32'd2;
        mo_me  = 32'd3;
        rs     = 5'd4;
        rt     = 5'd4;
        sweep_exp[0] = 32'd4;
        sweep_exp[1] = 32'd1;
        sweep_exp[2] = 32'd2;
        sweep_exp[3] = 32'd3;
        b_select = 2'b00;
        for (int i = 0; i < 4; i++) begin
            a_select = 2'(i);
            check_output($sformatf("a_sel_%0d", i), 32'd4, 32'd4, sweep_exp[i], 32'd4);
        end
        a_select = 2'b01;
        for (int i = 0; i < 4; i++) begin
            b_select = 2'(i);
            check_output($sformatf("b_sel_%0d", i), 32'd4, 32'd4, 32'd1, sweep_exp[i]);
        end
        a_select = 2'b00;
        b_select = 2'b00;

        // Asynchronous reset while clock is high, then a write attempt under reset
        apply_stimulus(5'd10, 32'h55);
        rs = 5'd10;
        rt = 5'd4;
        check_output("r10_loaded", 32'h55, 32'd4, 32'h55, 32'd4);
        @(posedge clock);
        #2;
        reset_0 = 1'b1;
        check_output("async_reset_clear", 32'h0, 32'h0, 32'h0, 32'h0);
        we     = 1'b1;
        rw     = 5'd10;
        data_w = 32'h77;
        @(negedge clock);
        #2;
        check_output("write_in_reset", 32'h0, 32'h0, 32'h0, 32'h0);
        we = 1'b0;
        #1;
        reset_0 = 1'b0;
        @(posedge clock);
        #2;
        check_output("after_reset", 32'h0, 32'h0, 32'h0, 32'h0);

        #5;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 50000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
